// File: rtl/traffic_phase_controller_pkg.sv
// Shared encodings for the two-road traffic phase controller: FSM states,
// approach directions and one-hot lamp patterns.
package traffic_pkg;

  localparam logic [2:0] ST_ALLRED_A  = 3'd0;
  localparam logic [2:0] ST_NS_GREEN  = 3'd1;
  localparam logic [2:0] ST_NS_YELLOW = 3'd2;
  localparam logic [2:0] ST_ALLRED_B  = 3'd3;
  localparam logic [2:0] ST_EW_GREEN  = 3'd4;
  localparam logic [2:0] ST_EW_YELLOW = 3'd5;
  localparam logic [2:0] ST_WALK      = 3'd6;

  typedef enum logic [2:0] {
    ALLRED_A  = ST_ALLRED_A,
    NS_GREEN  = ST_NS_GREEN,
    NS_YELLOW = ST_NS_YELLOW,
    ALLRED_B  = ST_ALLRED_B,
    EW_GREEN  = ST_EW_GREEN,
    EW_YELLOW = ST_EW_YELLOW,
    WALK      = ST_WALK
  } state_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  // Lamp order is {red,yellow,green}
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  function automatic state_t green_of(input dir_t dir);
    return (dir == DIR_NS) ? NS_GREEN : EW_GREEN;
  endfunction

endpackage

// File: rtl/traffic_phase_controller_phase_timer.sv
// Loadable down-counter measuring the seconds left in the current phase.
// expire flags the tick that consumes the last second.
module phase_timer #(
  parameter int CNT_W     = 5,
  parameter int RESET_VAL = 1
) (
  input  logic             clock,
  input  logic             reset_sync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  assign expire = tick && (count == CNT_W'(1));

  // load wins over tick: a transition edge is always also a tick edge
  always_ff @(posedge clock or posedge reset_sync) begin
    if (reset_sync) begin
      count <= CNT_W'(RESET_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (tick) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-road intersection sequencer driven by a 1 Hz enable, with an optional
// pedestrian WALK phase inserted at the all-red clearance.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_SEC  = 8,
  parameter int YELLOW_SEC = 3,
  parameter int ALLRED_SEC = 1,
  parameter int WALK_SEC   = 5,
  parameter int CNT_W      = 5
) (
  input  logic             clock,
  input  logic             reset_sync,
  input  logic             enable_1Hz,
  input  logic             ped_req,
  output logic             ped_ack,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk,
  output logic [CNT_W-1:0] sec_left,
  output logic             phase_done
);

  state_t           state;
  state_t           state_next;
  dir_t             next_dir;
  dir_t             next_dir_next;
  logic             ped_pending;
  logic             ped_pending_next;
  logic             ped_set;
  logic             expire;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;

  phase_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (ALLRED_SEC)
  ) u_timer (
    .clock      (clock),
    .reset_sync (reset_sync),
    .load       (expire),
    .load_val   (load_val),
    .tick       (enable_1Hz),
    .count      (count),
    .expire     (expire)
  );

  assign ped_set = ped_req && !ped_pending && (state != WALK);

  // A request arriving on the expiring ALLRED tick is latched but sees the old
  // ped_pending, so it waits for the next clearance phase.
  always_comb begin
    state_next    = state;
    next_dir_next = next_dir;
    if (expire) begin
      case (state)
        ALLRED_A: begin
          if (ped_pending) begin
            state_next    = WALK;
            next_dir_next = DIR_NS;
          end else begin
            state_next = NS_GREEN;
          end
        end
        NS_GREEN:  state_next = NS_YELLOW;
        NS_YELLOW: state_next = ALLRED_B;
        ALLRED_B: begin
          if (ped_pending) begin
            state_next    = WALK;
            next_dir_next = DIR_EW;
          end else begin
            state_next = EW_GREEN;
          end
        end
        EW_GREEN:  state_next = EW_YELLOW;
        EW_YELLOW: state_next = ALLRED_A;
        WALK:      state_next = green_of(next_dir);
        default:   state_next = ALLRED_A;
      endcase
    end
  end

  always_comb begin
    ped_pending_next = ped_pending;
    if (expire && (state_next == WALK)) begin
      ped_pending_next = 1'b0;
    end else if (ped_set) begin
      ped_pending_next = 1'b1;
    end
  end

  always_comb begin
    load_val = CNT_W'(ALLRED_SEC);
    case (state_next)
      NS_GREEN, EW_GREEN:   load_val = CNT_W'(GREEN_SEC);
      NS_YELLOW, EW_YELLOW: load_val = CNT_W'(YELLOW_SEC);
      WALK:                 load_val = CNT_W'(WALK_SEC);
      default:              load_val = CNT_W'(ALLRED_SEC);
    endcase
  end

  always_ff @(posedge clock or posedge reset_sync) begin
    if (reset_sync) begin
      state       <= ALLRED_A;
      next_dir    <= DIR_NS;
      ped_pending <= 1'b0;
      ped_ack     <= 1'b0;
      phase_done  <= 1'b0;
    end else begin
      state       <= state_next;
      next_dir    <= next_dir_next;
      ped_pending <= ped_pending_next;
      ped_ack     <= ped_set;
      phase_done  <= expire;
    end
  end

  // Lamps default to red so any state not listed is safe
  always_comb begin
    ns_light = L_RED;
    ew_light = L_RED;
    walk     = 1'b0;
    case (state)
      NS_GREEN:  ns_light = L_GRN;
      NS_YELLOW: ns_light = L_YEL;
      EW_GREEN:  ew_light = L_GRN;
      EW_YELLOW: ew_light = L_YEL;
      WALK:      walk     = 1'b1;
      default: begin
        ns_light = L_RED;
        ew_light = L_RED;
      end
    endcase
  end

  assign sec_left = count;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench for traffic_phase_controller: stimulus queues the expected
// phase sequence, a monitor checks every phase_done entry against it.
module tb_traffic_phase_controller;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam int P_ALLA = 0, P_NSG = 1, P_NSY = 2, P_ALLB = 3;
  localparam int P_EWG = 4, P_EWY = 5, P_WALK = 6;

  typedef struct {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       wlk;
    int         dur;
    int         acks;
    string      name;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_sync = 1'b1;
  logic       enable_1Hz = 1'b0;
  logic       ped_req = 1'b0;
  logic       ped_ack;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [4:0] sec_left;
  logic       phase_done;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   conflicts = 0;
  int   init_acks = 0;
  bit   tied_high = 1'b0;
  int   tick_div = 0;

  traffic_phase_controller dut (
    .clock      (clock),
    .reset_sync (reset_sync),
    .enable_1Hz (enable_1Hz),
    .ped_req    (ped_req),
    .ped_ack    (ped_ack),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .walk       (walk),
    .sec_left   (sec_left),
    .phase_done (phase_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_phase(input int ph, input int acks);
    exp_t e;
    e.ns = RED; e.ew = RED; e.wlk = 1'b0; e.acks = acks;
    case (ph)
      P_ALLA: begin e.dur = 1; e.name = "allred_a"; end
      P_NSG:  begin e.dur = 8; e.ns = GRN; e.name = "ns_green"; end
      P_NSY:  begin e.dur = 3; e.ns = YEL; e.name = "ns_yellow"; end
      P_ALLB: begin e.dur = 1; e.name = "allred_b"; end
      P_EWG:  begin e.dur = 8; e.ew = GRN; e.name = "ew_green"; end
      P_EWY:  begin e.dur = 3; e.ew = YEL; e.name = "ew_yellow"; end
      default: begin e.dur = 5; e.wlk = 1'b1; e.name = "walk"; end
    endcase
    exp_q.push_back(e);
  endtask

  // Tick source: one pulse every 10 clocks, or continuously high
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (reset_sync) tick_div = 0;
      else tick_div = (tick_div == 9) ? 0 : tick_div + 1;
      enable_1Hz = !reset_sync && (tied_high || tick_div == 9);
    end
  end

  // Monitor: per-cycle safety checks and scoreboard pop on each phase entry
  initial begin
    int   tick_cnt;
    int   ack_cnt;
    int   prev_dur;
    int   prev_acks;
    exp_t e;
    tick_cnt = 0; ack_cnt = 0; prev_dur = 1; prev_acks = 0;
    forever begin
      @(negedge clock);
      if (reset_sync) begin
        tick_cnt = 0; ack_cnt = 0; prev_dur = 1; prev_acks = init_acks;
      end else begin
        if ((ns_light != RED && ew_light != RED) || !$onehot(ns_light) ||
            !$onehot(ew_light) || (walk && (ns_light != RED || ew_light != RED)))
          conflicts++;
        if (phase_done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_phase_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check({"ticks_before_", e.name}, tick_cnt, prev_dur);
            check({"acks_before_", e.name}, ack_cnt, prev_acks);
            check({"ns_light_", e.name}, int'(ns_light), int'(e.ns));
            check({"ew_light_", e.name}, int'(ew_light), int'(e.ew));
            check({"walk_", e.name}, int'(walk), int'(e.wlk));
            check({"sec_left_", e.name}, int'(sec_left), e.dur);
            prev_dur = e.dur;
            prev_acks = e.acks;
          end
          tick_cnt = 0;
          ack_cnt = 0;
        end
        if (ped_ack) ack_cnt++;
        if (enable_1Hz) tick_cnt++;
      end
    end
  end

  task automatic assert_reset(input string tag);
    @(posedge clock);
    #3 reset_sync = 1'b1;
    #1;
    check({tag, "_rst_ns"}, int'(ns_light), int'(RED));
    check({tag, "_rst_ew"}, int'(ew_light), int'(RED));
    check({tag, "_rst_walk"}, int'(walk), 0);
    check({tag, "_rst_ack"}, int'(ped_ack), 0);
    check({tag, "_rst_done"}, int'(phase_done), 0);
    check({tag, "_rst_sec"}, int'(sec_left), 1);
    exp_q.delete();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clock);
    #3 reset_sync = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clock);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    // Basic cycle with a wrap back to NS_GREEN
    init_acks = 0;
    assert_reset("s1");
    push_phase(P_NSG, 0); push_phase(P_NSY, 0); push_phase(P_ALLB, 0);
    push_phase(P_EWG, 0); push_phase(P_EWY, 0); push_phase(P_ALLA, 0);
    push_phase(P_NSG, 0);
    release_reset();
    drain("s1");

    // Single pedestrian pulse at sec_left=5 of NS_GREEN
    assert_reset("s2");
    push_phase(P_NSG, 1); push_phase(P_NSY, 0); push_phase(P_ALLB, 0);
    push_phase(P_WALK, 0); push_phase(P_EWG, 0); push_phase(P_EWY, 0);
    release_reset();
    n = 0;
    do begin
      @(posedge clock);
      #3 n++;
    end while (!(ns_light == GRN && sec_left == 5'd5) && n < 500);
    check("s2_found_ns_green5", int'(ns_light == GRN && sec_left == 5'd5), 1);
    ped_req = 1'b1;
    @(posedge clock);
    #3 ped_req = 1'b0;
    drain("s2");

    // Request held high across several WALK insertions
    init_acks = 1;
    assert_reset("s3");
    push_phase(P_WALK, 0); push_phase(P_NSG, 1); push_phase(P_NSY, 0);
    push_phase(P_ALLB, 0); push_phase(P_WALK, 0); push_phase(P_EWG, 1);
    push_phase(P_EWY, 0); push_phase(P_ALLA, 0); push_phase(P_WALK, 0);
    push_phase(P_NSG, 1); push_phase(P_NSY, 0); push_phase(P_ALLB, 0);
    push_phase(P_WALK, 0);
    release_reset();
    ped_req = 1'b1;
    repeat (425) @(posedge clock);
    #3 ped_req = 1'b0;
    drain("s3");
    init_acks = 0;

    // Request on the very tick that expires ALLRED_A
    assert_reset("s4");
    push_phase(P_NSG, 1); push_phase(P_NSY, 0); push_phase(P_ALLB, 0);
    push_phase(P_WALK, 0); push_phase(P_EWG, 0);
    release_reset();
    n = 0;
    do begin
      @(posedge clock);
      #3 n++;
    end while (!enable_1Hz && n < 50);
    check("s4_first_tick_in_allred", int'(enable_1Hz && ns_light == RED && ew_light == RED), 1);
    ped_req = 1'b1;
    @(posedge clock);
    #3 ped_req = 1'b0;
    drain("s4");

    // Reset in EW_GREEN with a pending request: request must be dropped
    assert_reset("s5a");
    push_phase(P_NSG, 0); push_phase(P_NSY, 0); push_phase(P_ALLB, 0);
    push_phase(P_EWG, 0);
    release_reset();
    drain("s5a");
    #3 ped_req = 1'b1;
    @(posedge clock);
    #3 ped_req = 1'b0;
    check("s5_ack_in_ew_green", int'(ped_ack), 1);
    check("s5_still_ew_green", int'(ew_light), int'(GRN));
    assert_reset("s5b");
    push_phase(P_NSG, 0); push_phase(P_NSY, 0); push_phase(P_ALLB, 0);
    push_phase(P_EWG, 0);
    release_reset();
    drain("s5b");

    // enable_1Hz tied high: one second per clock
    tied_high = 1'b1;
    assert_reset("s6");
    push_phase(P_NSG, 0); push_phase(P_NSY, 0); push_phase(P_ALLB, 0);
    push_phase(P_EWG, 0); push_phase(P_EWY, 0); push_phase(P_ALLA, 0);
    push_phase(P_NSG, 0);
    release_reset();
    drain("s6");
    assert_reset("s7");
    tied_high = 1'b0;

    check("light_conflicts", conflicts, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
